// File: rtl/pic_ram_loader.sv
// Byte-serial pixel stream to sequential picture-RAM writes, with a frame_done pulse per frame.
// Optional build macro PIC_BINARIZE_EN thresholds each pixel at THRESH before it is written.
module pic_ram_loader #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int NUM_PIX = 784,
    parameter int THRESH  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              frame_done
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIX - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic                accept;
    logic [DATA_W-1:0]   pix_wr;

`ifdef PIC_BINARIZE_EN
    assign pix_wr = (in_data >= DATA_W'(THRESH)) ? {DATA_W{1'b1}} : '0;
`else
    logic unused_thresh;
    assign pix_wr        = in_data;
    assign unused_thresh = ^DATA_W'(THRESH);
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        accept    = in_valid & in_ready_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d   = FILL;
                    pix_cnt_d = '0;
                end
            end
            FILL: begin
                // abort takes priority: a beat offered in the same cycle is dropped unwritten
                if (abort) begin
                    state_d   = IDLE;
                    pix_cnt_d = '0;
                end else if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = pix_cnt_q;
                    wr_data_d = pix_wr;
                    if (pix_cnt_q == LAST_PIX) begin
                        state_d   = DONE;
                        pix_cnt_d = '0;
                    end else begin
                        pix_cnt_d = pix_cnt_q + ADDR_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        in_ready_d   = (state_d == FILL);
        busy_d       = (state_d == FILL);
        frame_done_d = (state_q == DONE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pix_cnt_q    <= '0;
            in_ready_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            in_ready_q   <= in_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pic_ram_loader.sv
// Directed bench for pic_ram_loader: reference model of the handshake plus a write scoreboard.
module tb_pic_ram_loader;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 8;
    localparam int NUM_PIX = 784;
    localparam int THRESH  = 128;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              frame_done;

    pic_ram_loader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_PIX(NUM_PIX), .THRESH(THRESH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               sb[$];
    int                checks = 0;
    int                errors = 0;
    int                ms = 0;          // model state: 0 idle, 1 fill, 2 done
    int                mcnt = 0;
    logic [ADDR_W-1:0] hold_addr = '0;
    logic [DATA_W-1:0] hold_data = '0;
    logic [ADDR_W-1:0] seen_addr = '0;
    int                n_wr = 0;
    int                n_fd = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_data(input logic [DATA_W-1:0] d);
`ifdef PIC_BINARIZE_EN
        return (32'(d) >= THRESH) ? {DATA_W{1'b1}} : '0;
`else
        return d;
`endif
    endfunction

    // One clock: predict from the current inputs, advance, then compare #1 after the edge.
    task automatic step();
        logic acc;
        logic exp_wr;
        logic exp_fd;
        int   nms;
        int   ncnt;
        wr_t  e;
        acc    = (ms == 1) && in_valid && !abort;
        exp_wr = acc;
        exp_fd = (ms == 2);
        nms    = ms;
        ncnt   = mcnt;
        if (acc) sb.push_back({mcnt[ADDR_W-1:0], exp_data(in_data)});
        case (ms)
            0: if (start && !abort) begin nms = 1; ncnt = 0; end
            1: begin
                if (abort) begin
                    nms = 0; ncnt = 0;
                end else if (acc) begin
                    if (mcnt == NUM_PIX - 1) begin nms = 2; ncnt = 0; end
                    else ncnt = mcnt + 1;
                end
            end
            default: nms = 0;
        endcase
        @(posedge clk);
        #1;
        ms   = nms;
        mcnt = ncnt;
        check("in_ready", 32'(in_ready), 32'(ms == 1));
        check("busy", 32'(busy), 32'(ms == 1));
        check("frame_done", 32'(frame_done), 32'(exp_fd));
        check("wr_en", 32'(wr_en), 32'(exp_wr));
        if (wr_en && sb.size() > 0) begin
            e = sb.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(e.addr));
            check("wr_data", 32'(wr_data), 32'(e.data));
            hold_addr = e.addr;
            hold_data = e.data;
            seen_addr = wr_addr;
            n_wr++;
        end else begin
            check("wr_addr_hold", 32'(wr_addr), 32'(hold_addr));
            check("wr_data_hold", 32'(wr_data), 32'(hold_data));
        end
        if (frame_done) n_fd++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    task automatic model_reset();
        ms = 0; mcnt = 0;
        sb.delete();
        hold_addr = '0; hold_data = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    logic [DATA_W-1:0] bin_in[4];
    logic [DATA_W-1:0] bin_exp[4];
    int                guard;

    initial begin
        // Power-on reset and idle.
        #2;
        check_all_zero("por");
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (5) step();

        // Full frame, back-to-back source.
        n_wr = 0; n_fd = 0;
        pulse_start();
        in_valid = 1'b1;
        for (int i = 0; i < NUM_PIX; i++) begin
            in_data = i[DATA_W-1:0];
            step();
        end
        in_valid = 1'b0;
        check("full_last_addr", 32'(seen_addr), 32'd783);
        step();
        step();
        check("full_wr_count", 32'(n_wr), 32'(NUM_PIX));
        check("full_fd_count", 32'(n_fd), 32'd1);

        // Gapped source.
        n_wr = 0; n_fd = 0; guard = 0;
        pulse_start();
        while (ms != 2 && guard < 20000) begin
            in_valid = ($urandom_range(0, 3) == 0) || ($urandom_range(0, 1) == 1);
            in_data  = DATA_W'($urandom);
            step();
            guard++;
        end
        in_valid = 1'b0;
        step();
        step();
        check("gap_wr_count", 32'(n_wr), 32'(NUM_PIX));
        check("gap_fd_count", 32'(n_fd), 32'd1);

        // Abort after 100 pixels, together with a valid beat.
        n_wr = 0; n_fd = 0;
        pulse_start();
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data = DATA_W'(i + 7);
            step();
        end
        abort = 1'b1;
        in_data = 8'hA5;
        step();
        abort = 1'b0;
        in_valid = 1'b0;
        repeat (3) step();
        check("abort_last_addr", 32'(seen_addr), 32'd99);
        check("abort_wr_count", 32'(n_wr), 32'd100);
        check("abort_fd_count", 32'(n_fd), 32'd0);
        pulse_start();
        in_valid = 1'b1;
        in_data = 8'h3C;
        step();
        check("restart_addr", 32'(seen_addr), 32'd0);
        in_valid = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;

        // start mid-frame and during DONE are ignored.
        n_wr = 0; n_fd = 0;
        pulse_start();
        in_valid = 1'b1;
        for (int i = 0; i < NUM_PIX; i++) begin
            in_data = DATA_W'(i * 3);
            start = (i == 300);
            step();
        end
        start = 1'b0;
        in_valid = 1'b0;
        check("ign_last_addr", 32'(seen_addr), 32'd783);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        check("ign_wr_count", 32'(n_wr), 32'(NUM_PIX));
        check("ign_fd_count", 32'(n_fd), 32'd1);
        check("ign_busy_after_done", 32'(busy), 32'd0);

        // Threshold boundary pixels.
        bin_in = '{8'h00, 8'h7F, 8'h80, 8'hFF};
`ifdef PIC_BINARIZE_EN
        bin_exp = '{8'h00, 8'h00, 8'hFF, 8'hFF};
`else
        bin_exp = '{8'h00, 8'h7F, 8'h80, 8'hFF};
`endif
        pulse_start();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = bin_in[i];
            step();
            check("bin_wr_data", 32'(wr_data), 32'(bin_exp[i]));
        end
        in_valid = 1'b0;

        // Asynchronous reset in the middle of a frame.
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            in_data = DATA_W'(i);
            step();
        end
        rst = 1'b0;
        #1;
        check_all_zero("mid_rst");
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (5) step();
        check("post_rst_in_ready", 32'(in_ready), 32'd0);
        check("post_rst_wr_en", 32'(wr_en), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
